// File: rtl/pixel_shuffle_streamer.sv
// pixel_shuffle_streamer
//   Captures a whole C*R*R*H*W tensor on start and streams it out one element
//   per accepted beat, rearranged either as a pixel shuffle (depth-to-space,
//   output C x H*R x W*R) or a pixel unshuffle (space-to-depth, output
//   C*R*R x H x W). Output order is channel-major: co slowest, ow fastest.
//
// Ports
//   clk           single clock
//   rst           asynchronous active-high reset
//   start         job request, honoured in IDLE only
//   mode          0 = shuffle, 1 = unshuffle, captured with start
//   in_data_flat  N elements, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid     out_data holds a valid element (high throughout RUN)
//   out_ready     consumer accepts the current element
//   out_data      current output element
//   out_last      current element is the final one (index N-1)
//   out_index     linear output index of the current element
//   busy          high in RUN and DONE
//   done          one-cycle pulse after the last beat
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for start, outputs quiet
//   RUN    | streaming elements, out_valid held high
//   DONE   | one-cycle done pulse, start ignored
module pixel_shuffle_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int C          = 64,
    parameter int R          = 2,
    parameter int H          = 4,
    parameter int W          = 4,
    localparam int N         = C * R * R * H * W,
    localparam int IW        = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [N*DATA_WIDTH-1:0] in_data_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [IW-1:0]           out_index,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = ($clog2(C) > 1) ? $clog2(C) : 1;
    localparam int RW = ($clog2(R) > 1) ? $clog2(R) : 1;
    localparam int HW = ($clog2(H) > 1) ? $clog2(H) : 1;
    localparam int WW = ($clog2(W) > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] C_MAX    = CW'(C - 1);
    localparam logic [RW-1:0] R_MAX    = RW'(R - 1);
    localparam logic [HW-1:0] H_MAX    = HW'(H - 1);
    localparam logic [WW-1:0] W_MAX    = WW'(W - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  mode_q;
    logic [DATA_WIDTH-1:0] mem [N];

    // Five digits shared by both modes:
    //   shuffle:   co = c,            oh = y*R + p, ow = x*R + q
    //   unshuffle: co = (c*R + p)*R + q, oh = y,    ow = x
    // Only the carry order between digits differs with mode, which avoids
    // any divide/modulo by R in the datapath.
    logic [CW-1:0] c_q;
    logic [RW-1:0] p_q;
    logic [RW-1:0] q_q;
    logic [HW-1:0] y_q;
    logic [WW-1:0] x_q;
    logic [IW-1:0] idx_q;

    logic c_max, p_max, q_max, y_max, x_max;
    logic inc_c, inc_p, inc_q, inc_y, inc_x;
    logic wrap_all;

    logic run;
    logic beat;
    logic take_start;

    int            src_shuf;
    int            src_unsh;
    logic [IW-1:0] src;

    assign run        = (state_q == S_RUN);
    assign beat       = run && out_ready;
    assign take_start = (state_q == S_IDLE) && start;

    assign c_max = (c_q == C_MAX);
    assign p_max = (p_q == R_MAX);
    assign q_max = (q_q == R_MAX);
    assign y_max = (y_q == H_MAX);
    assign x_max = (x_q == W_MAX);

    // Carry chain: shuffle q->x->p->y->c, unshuffle x->y->q->p->c.
    always_comb begin
        inc_c    = 1'b0;
        inc_p    = 1'b0;
        inc_q    = 1'b0;
        inc_y    = 1'b0;
        inc_x    = 1'b0;
        wrap_all = 1'b0;
        if (mode_q == 1'b0) begin
            inc_q    = 1'b1;
            inc_x    = q_max;
            inc_p    = q_max && x_max;
            inc_y    = q_max && x_max && p_max;
            inc_c    = q_max && x_max && p_max && y_max;
            wrap_all = q_max && x_max && p_max && y_max && c_max;
        end else begin
            inc_x    = 1'b1;
            inc_y    = x_max;
            inc_q    = x_max && y_max;
            inc_p    = x_max && y_max && q_max;
            inc_c    = x_max && y_max && q_max && p_max;
            wrap_all = x_max && y_max && q_max && p_max && c_max;
        end
    end

    // Source element address for the current output position.
    always_comb begin
        src_shuf = ((int'(c_q) * R * R + int'(p_q) * R + int'(q_q)) * H
                    + int'(y_q)) * W + int'(x_q);
        src_unsh = (int'(c_q) * H * R + int'(y_q) * R + int'(p_q)) * W * R
                   + int'(x_q) * R + int'(q_q);
        src      = mode_q ? IW'(src_unsh) : IW'(src_shuf);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (beat && wrap_all) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            c_q    <= '0;
            p_q    <= '0;
            q_q    <= '0;
            y_q    <= '0;
            x_q    <= '0;
            idx_q  <= '0;
        end else if (take_start) begin
            mode_q <= mode;
            c_q    <= '0;
            p_q    <= '0;
            q_q    <= '0;
            y_q    <= '0;
            x_q    <= '0;
            idx_q  <= '0;
        end else if (beat) begin
            if (inc_c) c_q <= c_max ? '0 : c_q + 1'b1;
            if (inc_p) p_q <= p_max ? '0 : p_q + 1'b1;
            if (inc_q) q_q <= q_max ? '0 : q_q + 1'b1;
            if (inc_y) y_q <= y_max ? '0 : y_q + 1'b1;
            if (inc_x) x_q <= x_max ? '0 : x_q + 1'b1;
            idx_q <= wrap_all ? '0 : idx_q + 1'b1;
        end
    end

    // Job buffer has no reset; its contents only matter once a start has
    // reloaded it.
    always_ff @(posedge clk) begin
        if (take_start) begin
            for (int k = 0; k < N; k++) begin
                mem[k] <= in_data_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs are gated by state so reset forces them to zero immediately.
    always_comb begin
        out_valid = run;
        out_data  = run ? mem[src] : '0;
        out_index = run ? idx_q : '0;
        out_last  = run && (idx_q == LAST_IDX);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_pixel_shuffle_streamer.sv
module tb_pixel_shuffle_streamer;

    localparam int DW = 8;
    localparam int SN = 16;
    localparam int BN = 108;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              s_start, s_mode, s_valid, s_ready, s_last, s_busy, s_done;
    logic [SN*DW-1:0]  s_in;
    logic [DW-1:0]     s_out;
    logic [3:0]        s_index;

    logic              b_start, b_mode, b_valid, b_ready, b_last, b_busy, b_done;
    logic [BN*DW-1:0]  b_in;
    logic [DW-1:0]     b_out;
    logic [6:0]        b_index;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_shuf [16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};
    int exp_unsh [16] = '{0, 2, 8, 10, 1, 3, 9, 11, 4, 6, 12, 14, 5, 7, 13, 15};

    logic [SN*DW-1:0] d_lin;
    logic [SN*DW-1:0] d_alt;
    logic [DW-1:0]    orig [BN];
    logic [DW-1:0]    mid  [BN];
    logic [DW-1:0]    fin  [BN];

    pixel_shuffle_streamer #(
        .DATA_WIDTH(DW), .C(1), .R(2), .H(2), .W(2)
    ) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .mode(s_mode),
        .in_data_flat(s_in), .out_valid(s_valid), .out_ready(s_ready),
        .out_data(s_out), .out_last(s_last), .out_index(s_index),
        .busy(s_busy), .done(s_done)
    );

    pixel_shuffle_streamer #(
        .DATA_WIDTH(DW), .C(2), .R(3), .H(2), .W(3)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
        .in_data_flat(b_in), .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_out), .out_last(b_last), .out_index(b_index),
        .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_small(input logic md, input logic [SN*DW-1:0] data);
        s_start = 1'b1;
        s_mode  = md;
        s_in    = data;
        tick();
        s_start = 1'b0;
        check("first_valid_latency", s_valid, 1);
    endtask

    // Runs the small job to completion, checking every cycle against the
    // expected order. poke_beat injects a start with other data; rst_beat
    // asserts reset instead of accepting that beat.
    task automatic drain_small(input logic md, input bit rnd, input int poke_beat, input int rst_beat);
        int beat  = 0;
        int cyc   = 0;
        int dones = 0;
        int e;
        while (beat < 16 && cyc < 300) begin
            cyc++;
            e = md ? exp_unsh[beat] : exp_shuf[beat];
            check("valid_in_run", s_valid, 1);
            check("busy_in_run", s_busy, 1);
            check("data", s_out, e);
            check("index", s_index, beat);
            check("last", s_last, (beat == 15));
            if (beat == rst_beat) begin
                rst = 1'b1;
                #1;
                check("rst_valid", s_valid, 0);
                check("rst_last", s_last, 0);
                check("rst_index", s_index, 0);
                check("rst_data", s_out, 0);
                check("rst_busy", s_busy, 0);
                check("rst_done", s_done, 0);
                tick();
                check("rst_held_done", s_done, 0);
                rst = 1'b0;
                tick();
                check("post_rst_valid", s_valid, 0);
                check("post_rst_done", s_done, 0);
                check("post_rst_busy", s_busy, 0);
                return;
            end
            if (beat == poke_beat && s_start == 1'b0 && cyc == beat + 1) begin
                s_start = 1'b1;
                s_in    = d_alt;
            end else begin
                s_start = 1'b0;
            end
            s_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (s_ready) beat++;
            if (s_done) dones++;
            tick();
        end
        s_start = 1'b0;
        check("beat_count", beat, 16);
        check("no_done_in_run", dones, 0);
        check("done_pulse", s_done, 1);
        check("done_valid", s_valid, 0);
        check("done_busy", s_busy, 1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("after_done", s_done, 0);
        check("after_busy", s_busy, 0);
        check("start_in_done_ignored", s_valid, 0);
    endtask

    initial begin
        rst     = 1'b1;
        s_start = 1'b0; s_mode = 1'b0; s_ready = 1'b1; s_in = '0;
        b_start = 1'b0; b_mode = 1'b0; b_ready = 1'b1; b_in = '0;
        for (int k = 0; k < SN; k++) begin
            d_lin[k*DW +: DW] = DW'(k);
            d_alt[k*DW +: DW] = DW'(8'hA0 + k);
        end
        #1;
        check("reset_valid", s_valid, 0);
        check("reset_index", s_index, 0);
        check("reset_data", s_out, 0);
        tick();
        tick();
        check("reset_busy", s_busy, 0);
        check("reset_done", s_done, 0);
        check("reset_last", s_last, 0);
        rst = 1'b0;
        tick();
        check("idle_valid", s_valid, 0);

        // shuffle, then unshuffle started in the cycle right after done
        start_small(1'b0, d_lin);
        drain_small(1'b0, 1'b0, -1, -1);
        start_small(1'b1, d_lin);
        drain_small(1'b1, 1'b0, -1, -1);

        // back-pressure
        start_small(1'b0, d_lin);
        drain_small(1'b0, 1'b1, -1, -1);

        // start while busy with different data
        start_small(1'b0, d_lin);
        drain_small(1'b0, 1'b0, 5, -1);
        s_in = d_lin;

        // reset mid-job, then a fresh job
        start_small(1'b0, d_lin);
        drain_small(1'b0, 1'b0, -1, 7);
        start_small(1'b0, d_lin);
        drain_small(1'b0, 1'b0, -1, -1);

        // round trip on the larger instance
        begin
            int cnt;
            int cyc;
            for (int k = 0; k < BN; k++) begin
                orig[k] = DW'($urandom);
                b_in[k*DW +: DW] = orig[k];
            end
            b_mode  = 1'b0;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            check("rt_first_valid", b_valid, 1);
            cnt = 0;
            cyc = 0;
            while (cnt < BN && cyc < 1000) begin
                cyc++;
                b_ready = ($urandom_range(0, 1) == 1);
                if (b_valid && b_ready) begin
                    check("rt_shuf_index", b_index, cnt);
                    check("rt_shuf_last", b_last, (cnt == BN - 1));
                    mid[cnt] = b_out;
                    cnt++;
                end
                tick();
            end
            check("rt_shuf_count", cnt, BN);
            check("rt_shuf_done", b_done, 1);
            tick();
            for (int k = 0; k < BN; k++) b_in[k*DW +: DW] = mid[k];
            b_mode  = 1'b1;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            b_in    = '0;
            cnt = 0;
            cyc = 0;
            while (cnt < BN && cyc < 1000) begin
                cyc++;
                b_ready = ($urandom_range(0, 1) == 1);
                if (b_valid && b_ready) begin
                    fin[cnt] = b_out;
                    cnt++;
                end
                tick();
            end
            check("rt_unsh_count", cnt, BN);
            check("rt_unsh_done", b_done, 1);
            for (int k = 0; k < BN; k++) begin
                check("rt_element", fin[k], orig[k]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_shuffle_streamer.md
PIXEL_SHUFFLE_STREAMER -- requirements
Module: pixel_shuffle_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning bits per tensor element.
REQ-002 The block SHALL have parameter C, default 64, meaning the low-channel-count side of the rearrangement.
REQ-003 The block SHALL have parameter R, default 2, meaning the upscale factor; R >= 1.
REQ-004 The block SHALL have parameter H, default 4, meaning the low-resolution height.
REQ-005 The block SHALL have parameter W, default 4, meaning the low-resolution width.
REQ-006 The block SHALL define derived N = C*R*R*H*W as the element count; IW = max(1, clog2(N)).
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 The block SHALL have port start, input, 1 bit: job request, sampled in IDLE only.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 = shuffle, 1 = unshuffle; sampled with start.
REQ-011 The block SHALL have port in_data_flat, input, N*DATA_WIDTH bits: element k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts the element.
REQ-014 The block SHALL have port out_data, output, DATA_WIDTH bits: the current output element.
REQ-015 The block SHALL have port out_last, output, 1 bit: the current element is element N-1.
REQ-016 The block SHALL have port out_index, output, IW bits: the linear output index of the current element.
REQ-017 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-018 The block SHALL have port done, output, 1 bit: a one-cycle pulse after the last beat.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, RUN and DONE: IDLE -start-> RUN; RUN -(last beat accepted)-> DONE; DONE -> IDLE unconditionally.
REQ-020 In IDLE with start=1, the block SHALL capture in_data_flat and mode into internal registers and clear the counters; later input changes SHALL NOT affect the job.
REQ-021 The first out_valid SHALL occur in the cycle after the start is accepted, giving a latency of 1 cycle.
REQ-022 The block SHALL hold out_valid=1 throughout RUN; a beat transfers when out_valid && out_ready.
REQ-023 When out_ready=0, out_data, out_index and out_last SHALL remain stable.
REQ-024 Output order SHALL be channel-major with nested counters co (slowest), oh, ow (fastest), and out_index = (co*OH + oh)*OW + ow.
REQ-025 In shuffle mode, output dimensions SHALL be (C, H*R, W*R), with out(co,oh,ow) = in[((co*R*R + (oh%R)*R + ow%R)*H + oh/R)*W + ow/R].
REQ-026 In unshuffle mode, output dimensions SHALL be (C*R*R, H, W), with c=co/(R*R), i=(co%(R*R))/R, j=co%R, and out(co,oh,ow) = in[(c*H*R + oh*R + i)*W*R + ow*R + j].
REQ-027 Each counter SHALL wrap to 0 at its limit and carry into the next; the wrap of the final co counter on the last beat SHALL end the job.
REQ-028 When R=1, the output SHALL equal the input in linear order in both modes.
REQ-029 A start pulse in RUN or DONE SHALL be ignored and SHALL NOT queue; start in the same cycle as done SHALL be ignored.
REQ-030 The block SHALL accept a start in the cycle after done, when the FSM is in IDLE again.
REQ-031 done SHALL be 1 only in DONE; out_valid SHALL be 0 in IDLE and DONE.
REQ-032 The block SHALL perform no arithmetic on data; elements SHALL be moved bit-exact.
REQ-033 Index arithmetic SHALL be wide enough for N-1 without overflow.

Reset
REQ-034 On rst=1, asynchronously, the block SHALL force IDLE, out_valid=0, out_last=0, out_index=0, out_data=0, busy=0 and done=0.
REQ-035 Reset mid-RUN SHALL abort the job with no done pulse, and the next start after reset release SHALL begin a fresh job from index 0.
REQ-036 The captured buffer contents are don't-care after reset.

Verification
REQ-037 The bench SHALL cover shuffle: C=1, R=2, H=W=2, DATA_WIDTH=8, element k = k, mode=0, out_ready=1 -> 16 beats 0,4,1,5,8,12,9,13,2,6,3,7,10,14,11,15; out_last on beat 16; done pulses 1 cycle later.
REQ-038 The bench SHALL cover unshuffle with the same input, mode=1 -> 0,2,8,10,1,3,9,11,4,6,12,14,5,7,13,15.
REQ-039 The bench SHALL cover back-pressure: random out_ready (50%) during shuffle -> the same sequence as REQ-037, with no duplicate or dropped beats and stable outputs while stalled.
REQ-040 The bench SHALL cover start while busy: a second start at beat 5 with a different in_data_flat -> the first job completes unchanged, and exactly one done pulse occurs.
REQ-041 The bench SHALL cover reset mid-job: rst asserted at beat 7 -> all outputs 0 immediately, no done; a restart yields the full 16-beat sequence from 0.
REQ-042 The bench SHALL cover round trip: C=2, R=3, H=2, W=3, random data, shuffle then unshuffle of the collected stream -> output equals the original input.
